// File: rtl/psum_writeback.sv
// psum_writeback: packs the partial-sum pixel stream from the DSP chain tail into
// DATA_WIDTH words (lane 0 in the low bits), buffers them in a first-word-fall-through
// FIFO and streams them out with valid/ready. The final word of a layer carries m_last
// and done pulses once that word has left the FIFO.
// Build option: define PSUM_RELU_EN to clamp negative pixels to zero before packing.
module psum_writeback #(
    parameter int unsigned B_PIXEL    = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned B_COUNT    = 24,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [B_COUNT-1:0]    n_pixels,
    input  logic                  psum_valid,
    input  logic [B_PIXEL-1:0]    psum_i,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [FIFO_AW:0]      fifo_level
);

    localparam int unsigned LANES  = DATA_WIDTH / B_PIXEL;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned DEPTH  = 1 << FIFO_AW;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e state_q, state_d;

    // Layer bookkeeping and pack register
    logic [B_COUNT-1:0]    remaining_q, remaining_d;
    logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic                  overflow_q, overflow_d;

    // Datapath strobes
    logic                  start_accept;
    logic                  pix_accept;
    logic                  is_final_pix;
    logic                  push;
    logic                  push_last;
    logic [B_PIXEL-1:0]    pixel;
    logic [DATA_WIDTH-1:0] word;

    // FIFO storage: bit DATA_WIDTH is the last flag
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]    wptr_q, wptr_d;
    logic [FIFO_AW-1:0]    rptr_q, rptr_d;
    logic [FIFO_AW:0]      count_q, count_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  wr_en;

    assign start_accept = (state_q == StIdle) && start;
    assign pix_accept   = (state_q == StCollect) && psum_valid;
    assign is_final_pix = (remaining_q == B_COUNT'(1));
    // A word leaves the pack register when its top lane fills or the layer's last pixel lands
    assign push         = pix_accept && ((lane_cnt_q == LANE_W'(LANES - 1)) || is_final_pix);
    assign push_last    = pix_accept && is_final_pix;

    assign fifo_full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign pop          = !fifo_empty && m_ready;
    // When full, a push only lands if a pop frees a slot on the same edge
    assign wr_en        = push && (!fifo_full || pop);

    // Optional ReLU on the incoming pixel
    always_comb begin
`ifdef PSUM_RELU_EN
        pixel = psum_i[B_PIXEL-1] ? '0 : psum_i;
`else
        pixel = psum_i;
`endif
    end

    // Merge the incoming pixel into the current lane so a completed word is pushed this edge
    always_comb begin
        word = pack_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_cnt_q == LANE_W'(l)) begin
                word[l*B_PIXEL +: B_PIXEL] = pixel;
            end
        end
    end

    // Next-state for layer counters, pack register and sticky overflow
    always_comb begin
        remaining_d = remaining_q;
        lane_cnt_d  = lane_cnt_q;
        pack_d      = pack_q;
        overflow_d  = overflow_q;
        if (start_accept) begin
            remaining_d = n_pixels;
            lane_cnt_d  = '0;
            pack_d      = '0;
            overflow_d  = 1'b0;
        end else if (pix_accept) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - B_COUNT'(1);
            end
            if (push) begin
                // Clearing here keeps unfilled lanes of a final partial word at zero
                lane_cnt_d = '0;
                pack_d     = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + LANE_W'(1);
                pack_d     = word;
            end
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Layer counters and pack register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            remaining_q <= '0;
            lane_cnt_q  <= '0;
            pack_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            lane_cnt_q  <= lane_cnt_d;
            pack_q      <= pack_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) begin
            wptr_d = wptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + FIFO_AW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are only observed through the empty-gated read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= {push_last, word};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (n_pixels == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                // Advances even if the final word was dropped on a full FIFO
                if (push_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty || (pop && (count_q == (FIFO_AW + 1)'(1)))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and FIFO-facing outputs
    always_comb begin
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        overflow   = overflow_q;
        fifo_level = count_q;
        m_valid    = !fifo_empty;
        m_data     = fifo_empty ? '0 : mem[rptr_q][DATA_WIDTH-1:0];
        m_last     = !fifo_empty && mem[rptr_q][DATA_WIDTH];
    end

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: directed stimulus with a scoreboard queue of expected words; a
// negedge monitor pops and compares on every handshake and tracks done pulses.
module tb_psum_writeback;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [23:0] n_pixels;
    logic        psum_valid;
    logic [15:0] psum_i;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [4:0]  fifo_level;

    psum_writeback #(
        .B_PIXEL    (16),
        .DATA_WIDTH (64),
        .B_COUNT    (24),
        .FIFO_AW    (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .n_pixels   (n_pixels),
        .psum_valid (psum_valid),
        .psum_i     (psum_i),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    typedef logic [64:0] exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int done_cyc = 0;
    int last_xfer_cyc = 0;
    bit last_pending = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every transferred word against the scoreboard head
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (m_valid) valid_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (last_pending) begin
                        chk("done_after_last", 64'(cyc - last_xfer_cyc), 64'd1);
                        last_pending = 0;
                    end
                end
                if (m_valid && m_ready) begin
                    xfer_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected none", m_data);
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", m_data, e[63:0]);
                        chk("word_last", 64'(m_last), 64'(e[64]));
                    end
                    if (m_last) begin
                        last_pending  = 1;
                        last_xfer_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic do_start(input logic [23:0] n);
        start    = 1'b1;
        n_pixels = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pix(input logic [15:0] v);
        psum_valid = 1'b1;
        psum_i     = v;
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
    endtask

    task automatic expect_word(input logic last, input logic [63:0] d);
        sb.push_back({last, d});
    endtask

    task automatic wait_done(input string name, input int prev, input int bound);
        int n = 0;
        while (done_cnt <= prev && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(done_cnt - prev), 64'd1);
    endtask

    initial begin
        int d0, x0, v0, c0, dl;
        rstn       = 1'b0;
        start      = 1'b0;
        n_pixels   = '0;
        psum_valid = 1'b0;
        psum_i     = '0;
        m_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);

        // Full words, first-word latency and done timing
        expect_word(1'b0, 64'h0004_0003_0002_0001);
        expect_word(1'b1, 64'h0008_0007_0006_0005);
        d0 = done_cnt;
        do_start(24'd8);
        chk("collect_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            pix(16'(i));
            if (i == 3) chk("valid_before_px4", 64'(m_valid), 64'd0);
            if (i == 4) chk("valid_after_px4", 64'(m_valid), 64'd1);
        end
        wait_done("full_done", d0, 20);
        chk("idle_busy", 64'(busy), 64'd0);

        // Partial final word
        expect_word(1'b0, 64'h0014_0013_0012_0011);
        expect_word(1'b1, 64'h0000_0000_0000_0015);
        d0 = done_cnt;
        do_start(24'd5);
        for (int i = 0; i < 5; i++) pix(16'h0011 + 16'(i));
        wait_done("partial_done", d0, 20);

        // Zero count: done almost immediately and no words
        v0 = valid_cnt;
        d0 = done_cnt;
        c0 = cyc;
        do_start(24'd0);
        wait_done("zero_done", d0, 10);
        dl = done_cyc - c0;
        chk("zero_done_lat", 64'(dl >= 1 && dl <= 2), 64'd1);
        chk("zero_no_valid", 64'(valid_cnt - v0), 64'd0);

        // Pixels in IDLE and a start mid-layer are ignored
        x0 = xfer_cnt;
        d0 = done_cnt;
        repeat (3) pix(16'h0099);
        expect_word(1'b1, 64'h0034_0033_0032_0031);
        do_start(24'd4);
        pix(16'h0031);
        pix(16'h0032);
        do_start(24'd100);
        pix(16'h0033);
        pix(16'h0034);
        wait_done("glitch_done", d0, 20);
        chk("glitch_words", 64'(xfer_cnt - x0), 64'd1);

        // Reset mid-layer discards pending data and issues no done
        m_ready = 1'b0;
        do_start(24'd16);
        for (int i = 1; i <= 6; i++) pix(16'(i));
        chk("pre_rst_level", 64'(fifo_level), 64'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        m_ready = 1'b1;
        expect_word(1'b1, 64'h0024_0023_0022_0021);
        do_start(24'd4);
        for (int i = 0; i < 4; i++) pix(16'h0021 + 16'(i));
        wait_done("post_rst_done", d0, 20);

        // Backpressure and overflow: only the first 16 words survive
        m_ready = 1'b0;
        for (int w = 0; w < 16; w++) begin
            expect_word(1'b0, {16'(4*w+4), 16'(4*w+3), 16'(4*w+2), 16'(4*w+1)});
        end
        d0 = done_cnt;
        do_start(24'd80);
        for (int k = 1; k <= 80; k++) begin
            pix(16'(k));
            if (k == 64) begin
                chk("ovf_level_full", 64'(fifo_level), 64'd16);
                chk("ovf_not_yet", 64'(overflow), 64'd0);
                chk("stall_hold", m_data, 64'h0004_0003_0002_0001);
            end
            if (k == 68) begin
                chk("ovf_set", 64'(overflow), 64'd1);
                chk("ovf_level_held", 64'(fifo_level), 64'd16);
            end
        end
        chk("ovf_drain_busy", 64'(busy), 64'd1);
        x0 = xfer_cnt;
        m_ready = 1'b1;
        wait_done("ovf_done", d0, 60);
        chk("ovf_drained", 64'(xfer_cnt - x0), 64'd16);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // ReLU vector; the new start clears overflow
`ifdef PSUM_RELU_EN
        expect_word(1'b1, 64'h7FFF_0000_0002_0000);
`else
        expect_word(1'b1, 64'h7FFF_8000_0002_FFFF);
`endif
        d0 = done_cnt;
        do_start(24'd4);
        chk("ovf_cleared", 64'(overflow), 64'd0);
        pix(16'hFFFF);
        pix(16'h0002);
        pix(16'h8000);
        pix(16'h7FFF);
        wait_done("relu_done", d0, 20);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
